flexio_lane_serializer: RTL and testbench
=========================================

# flexio_lane_serializer

Downstream pin stage of the flexio co-processor. It accepts 32-bit words (4 lanes × 8 bits) from the PCPI flexio stage over a valid/ready handshake. It shifts each lane LSB-first onto its own IO pin, alongside a generated shift clock. It samples the same number of bits from the input pins and returns them as a receive word. A one-deep holding register allows back-to-back words with no idle bit periods.

## Interface
- LANES, 4, number of parallel pin lanes.
- BITS, 8, bits per lane per word. The word width is LANES*BITS.
- DIV_W, 8, width of the clock-divider setting.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  block enable. Low aborts activity synchronously.
- clkdiv  in  DIV_W  half-period of the shift clock, minus one, in clk cycles.
- in_valid  in  1  transmit word valid.
- in_ready  out  1  holding register empty.
- in_data  in  LANES*BITS  transmit word. Lane i is in_data[BITS*i+BITS-1 : BITS*i].
- rx_valid  out  1  captured word available.
- rx_ready  in  1  consumer takes the captured word.
- rx_data  out  LANES*BITS  captured word, same lane mapping as in_data.
- io_out  out  LANES  serial data pins.
- io_oe  out  LANES  output enables. All bits are equal.
- io_sclk  out  1  shift clock.
- busy  out  1  a word is shifting.
- done  out  1  one-cycle pulse at the end of each word.
- overrun  out  1  sticky flag: a captured word was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

## Operation
- Reset values: in_ready=1, rx_valid=0, rx_data=0, io_out=0, io_oe=0, io_sclk=0, busy=0, done=0, overrun=0. The FSM is in IDLE and the holding register is empty.
- Holding register:
  - in_ready = !hold_full.
  - When in_valid && in_ready at a clk edge, in_data is stored and hold_full is set.
- FSM states are IDLE, LOW and HIGH.
  - **IDLE**, when hold_full && enable: load the shift register from hold, clear hold_full, latch clkdiv into div_cfg, set bit_cnt=0, then go to LOW.
  - **LOW**: io_sclk=0. The current bit of each lane is on io_out. After div_cfg+1 cycles, go to HIGH. On that transition, sample io_in[i] into bit bit_cnt of rx lane i.
  - **HIGH**: io_sclk=1. After div_cfg+1 cycles:
    - If bit_cnt==BITS-1, the word is complete: pulse done and commit the rx shift register. Then, if hold_full && enable, reload as in IDLE and go to LOW; otherwise go to IDLE.
    - Otherwise, shift the tx register right by one per lane, increment bit_cnt and go to LOW.
- io_oe=1 and busy=1 in LOW and HIGH. In IDLE, io_oe=0 and io_out=0.
- div_cfg is held for the whole word. clkdiv changes take effect only at the next load.
- rx commit:
  - If rx_valid==0, or rx_ready is high in the same cycle, then rx_data ← captured word and rx_valid=1.
  - Otherwise the captured word is dropped, rx_data is unchanged, and overrun is set.
- rx_valid clears on rx_valid && rx_ready, unless a commit happens in the same cycle.
- Simultaneous set and clr_overrun: set wins.
- enable low while in LOW or HIGH: go to IDLE at the next edge. The shift register and bit_cnt are discarded. hold_full is cleared and no done pulse is produced. in_ready remains governed by hold_full.
- Reset mid-word has the same effect as power-on reset. No partial rx word is committed.

## Timing
- Bit period is 2*(div_cfg+1) clk cycles. Word period is 2*BITS*(div_cfg+1) cycles.
- Latency from an accept edge while IDLE:
  - io_oe and bit 0 appear on io_out after the following edge, i.e. a 1-cycle IDLE→LOW hop.
- Data changes only at LOW entry. Sampling happens at the edge where io_sclk rises.
- done and rx_valid rise in the same cycle, at the edge that ends the last HIGH phase.
- Back-to-back: if hold is full at word end, the next word's bit 0 is driven at that same edge. There are no idle cycles.
- A new word can be accepted into hold while the previous one shifts. Hold frees at each load.

## Structure
- Package flexio_pkg holds LANES, BITS, DIV_W defaults and the state enum {IDLE, LOW, HIGH}.
- Sub-module flexio_clkdiv is the phase counter:
  - inputs: div_cfg, run, restart.
  - output: one-cycle phase_end strobe.
  - The FSM toggles LOW/HIGH on phase_end.

## Test plan
- **Single word:** clkdiv=0, in_data=0x000000A5 → io_out[0] = 1,0,1,0,0,1,0,1, each held 2 cycles; io_out[3:1]=0; done 16 cycles after the first LOW cycle.
- **Loopback:** io_in=io_out, clkdiv=3, in_data=0x8040_2001 → rx_valid with rx_data=0x8040_2001; word period 64 cycles.
- **Back-to-back:** two words accepted (0x11223344, 0xFFFFFFFF), clkdiv=1 → io_sclk continuous with no gap; exactly 2 done pulses 32 cycles apart.
- **Overrun:** rx_ready=0, three words sent → rx_data holds the first word and overrun=1; clr_overrun clears overrun.
- **Abort:** enable drops during bit 4 → next cycle IDLE, io_oe=0, no done, rx_valid unchanged; in_ready=1.
- **Reset mid-word:** reset asserted asynchronously during HIGH → all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/flexio_pkg.sv
// Shared defaults and the serializer state encoding for the flexio pin stage.
package flexio_pkg;

    localparam int LANES_DEFAULT = 4;
    localparam int BITS_DEFAULT  = 8;
    localparam int DIV_W_DEFAULT = 8;

    // IDLE: pins released; LOW/HIGH: the two halves of one shift-clock period.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_e;

endpackage

// File: rtl/flexio_clkdiv.sv
// Phase counter for the shift clock: strobes phase_end on the last clk
// cycle of each half-period (div_cfg+1 cycles long) while run is high.
module flexio_clkdiv #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             run,
    input  logic             restart,
    output logic             phase_end
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             phase_end_s;

    // Half-period counter: held at zero when idle or restarting, wraps at div_cfg.
    always_comb begin
        cnt_d       = cnt_q;
        phase_end_s = run && (cnt_q == div_cfg);
        if (!run || restart) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (phase_end_s) begin
            cnt_d = {DIV_W{1'b0}};
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_end = phase_end_s;

endmodule

// File: rtl/flexio_lane_serializer.sv
// flexio pin stage: shifts each lane of a 32-bit word LSB-first onto its own
// pin with a generated shift clock, samples the input pins at each rising
// shift-clock edge and returns the sampled bits as a receive word. A one-deep
// holding register lets the next word start with no idle bit periods.
module flexio_lane_serializer
    import flexio_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT,
    parameter int BITS  = BITS_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      clkdiv,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*BITS-1:0] in_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [LANES*BITS-1:0] rx_data,
    input  logic [LANES-1:0]      io_in,
    output logic [LANES-1:0]      io_out,
    output logic [LANES-1:0]      io_oe,
    output logic                  io_sclk,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int W     = LANES * BITS;
    localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [W-1:0]       tx_q, tx_d;
    logic [W-1:0]       rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cfg_q, div_cfg_d;
    logic [W-1:0]       rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               overrun_q, overrun_d;
    logic               in_ready_q, in_ready_d;
    logic [LANES-1:0]   io_out_q, io_out_d;
    logic [LANES-1:0]   io_oe_q, io_oe_d;
    logic               io_sclk_q, io_sclk_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               phase_end_s;
    logic               run_s;
    logic               load_s;
    logic               commit_s;
    logic               abort_s;
    logic               accept_s;
    logic               active_d_s;

    assign run_s = (state_q != IDLE);

    flexio_clkdiv #(
        .DIV_W (DIV_W)
    ) u_clkdiv (
        .clk       (clk),
        .rst       (reset),
        .div_cfg   (div_cfg_q),
        .run       (run_s),
        .restart   (load_s),
        .phase_end (phase_end_s)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        rx_sh_d     = rx_sh_q;
        bit_cnt_d   = bit_cnt_q;
        div_cfg_d   = div_cfg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        done_d      = 1'b0;
        load_s      = 1'b0;
        commit_s    = 1'b0;
        abort_s     = 1'b0;
        accept_s    = in_valid && !hold_full_q;

        case (state_q)
            IDLE: begin
                if (hold_full_q && enable) begin
                    load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOW: begin
                if (!enable) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else if (phase_end_s) begin
                    // Rising shift-clock edge: capture the pins into bit bit_cnt.
                    state_d = HIGH;
                    for (int i = 0; i < LANES; i++) begin
                        for (int j = 0; j < BITS; j++) begin
                            if (bit_cnt_q == CNT_W'(j)) begin
                                rx_sh_d[BITS*i + j] = io_in[i];
                            end else begin
                                rx_sh_d[BITS*i + j] = rx_sh_q[BITS*i + j];
                            end
                        end
                    end
                end else begin
                    state_d = LOW;
                end
            end
            HIGH: begin
                if (!enable) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else if (phase_end_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        commit_s = 1'b1;
                        done_d   = 1'b1;
                        if (hold_full_q) begin
                            load_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        for (int i = 0; i < LANES; i++) begin
                            tx_d[BITS*i +: BITS] = {1'b0, tx_q[BITS*i+1 +: BITS-1]};
                        end
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        state_d   = LOW;
                    end
                end else begin
                    state_d = HIGH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Word load: the divider setting is frozen here for the whole word.
        if (load_s) begin
            tx_d      = hold_q;
            div_cfg_d = clkdiv;
            bit_cnt_d = {CNT_W{1'b0}};
            rx_sh_d   = {W{1'b0}};
            state_d   = LOW;
        end else begin
            div_cfg_d = div_cfg_q;
        end

        // Holding register: a word offered while empty is kept even if an
        // abort discards the pending one in the same cycle.
        if (accept_s) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end else if (load_s || abort_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end

        // Receive commit: a word arriving while the previous is still unread is dropped.
        if (commit_s && (!rx_valid_q || rx_ready)) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        // Sticky overrun; a drop in the same cycle as a clear keeps it set.
        if (commit_s && rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        active_d_s = (state_d != IDLE);
        in_ready_d = !hold_full_d;
        io_oe_d    = {LANES{active_d_s}};
        io_sclk_d  = (state_d == HIGH);
        busy_d     = active_d_s;
        for (int i = 0; i < LANES; i++) begin
            io_out_d[i] = active_d_s & tx_d[BITS*i];
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= {W{1'b0}};
            hold_full_q <= 1'b0;
            tx_q        <= {W{1'b0}};
            rx_sh_q     <= {W{1'b0}};
            bit_cnt_q   <= {CNT_W{1'b0}};
            div_cfg_q   <= {DIV_W{1'b0}};
            rx_data_q   <= {W{1'b0}};
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            io_out_q    <= {LANES{1'b0}};
            io_oe_q     <= {LANES{1'b0}};
            io_sclk_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            rx_sh_q     <= rx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cfg_q   <= div_cfg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            in_ready_q  <= in_ready_d;
            io_out_q    <= io_out_d;
            io_oe_q     <= io_oe_d;
            io_sclk_q   <= io_sclk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign io_out   = io_out_q;
    assign io_oe    = io_oe_q;
    assign io_sclk  = io_sclk_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_flexio_lane_serializer.sv
// Directed bench for flexio_lane_serializer: one task per scenario, inline checks.
module tb_flexio_lane_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  clkdiv;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic        io_sclk;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        clr_overrun;

    logic        loopback;
    logic [3:0]  io_in_force;

    int checks = 0;
    int errors = 0;

    assign io_in = loopback ? io_out : io_in_force;

    always #5 clk = ~clk;

    flexio_lane_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clkdiv      (clkdiv),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oe       (io_oe),
        .io_sclk     (io_sclk),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input string name);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: in_ready=%b required 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = -1;
        for (int n = 1; n <= max; n++) begin
            tick();
            if (done === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; clkdiv = 8'd0; in_valid = 1'b0; in_data = 32'd0;
        rx_ready = 1'b1; clr_overrun = 1'b0; loopback = 1'b0; io_in_force = 4'd0;
        #13;
        checks++;
        if ({in_ready, rx_valid, io_oe, io_sclk, busy, done, overrun, io_out} !== 14'b1_0_0000_0_0_0_0_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b",
                     {in_ready, rx_valid, io_oe, io_sclk, busy, done, overrun, io_out}, 14'b1_0_0000_0_0_0_0_0000);
        end
        checks++;
        if (rx_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rx_data: got %h required %h", rx_data, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        tick(); tick();
        checks++;
        if ({in_ready, io_oe, busy} !== 6'b1_0000_0) begin
            errors++;
            $display("FAIL reset_idle: got %b required %b", {in_ready, io_oe, busy}, 6'b1_0000_0);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] pat;
        pat = 8'hA5;
        clkdiv = 8'd0; rx_ready = 1'b1; io_in_force = 4'b0010;
        in_valid = 1'b1; in_data = 32'h0000_00A5;
        tick();                     // accept edge
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_hold_full: in_ready=%b required 0", in_ready);
        end
        tick();                     // load edge, first LOW cycle
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({io_oe, io_sclk, io_out, done, busy} !== {4'hF, k[0], 3'b000, pat[k/2], 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL single_cycle%0d: oe/sclk/out/done/busy=%b required %b", k,
                         {io_oe, io_sclk, io_out, done, busy}, {4'hF, k[0], 3'b000, pat[k/2], 1'b0, 1'b1});
            end
            tick();
        end
        checks++;
        if ({done, rx_valid, io_oe, busy} !== 7'b1_1_0000_0) begin
            errors++;
            $display("FAIL single_done: done/rx_valid/oe/busy=%b required %b", {done, rx_valid, io_oe, busy}, 7'b1_1_0000_0);
        end
        checks++;
        if (rx_data !== 32'h0000_FF00) begin
            errors++;
            $display("FAIL single_rx_data: got %h required %h", rx_data, 32'h0000_FF00);
        end
        tick();
        checks++;
        if ({done, rx_valid} !== 2'b00) begin
            errors++;
            $display("FAIL single_after: done/rx_valid=%b required 00", {done, rx_valid});
        end
    endtask

    task automatic test_loopback();
        int cyc;
        loopback = 1'b1; clkdiv = 8'd3; rx_ready = 1'b0;
        send_word(32'h8040_2001, "loopback");
        tick();                     // load edge
        clkdiv = 8'd0;              // must not affect the word in flight
        wait_done(200, cyc);
        checks++;
        if (cyc != 64) begin
            errors++;
            $display("FAIL loopback_period: got %0d cycles required 64", cyc);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h8040_2001) begin
            errors++;
            $display("FAIL loopback_rx: rx_valid=%b rx_data=%h required 1 80402001", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        tick();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL loopback_rx_clear: rx_valid=%b required 0", rx_valid);
        end
        loopback = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2, word;
        logic [3:0]  exp_out;
        int          b, ndone, first_done, last_done;
        w1 = 32'h1122_3344; w2 = 32'hFFFF_FFFF;
        clkdiv = 8'd1; rx_ready = 1'b1; io_in_force = 4'b0101;
        ndone = 0; first_done = -1; last_done = -1;
        in_valid = 1'b1; in_data = w1;
        tick();                     // accept w1
        in_data = w2;
        tick();                     // load w1, k = 0; w2 accepted at the next edge
        for (int k = 0; k < 70; k++) begin
            if (k == 1) in_valid = 1'b0;
            word = (k < 32) ? w1 : w2;
            b = (k % 32) / 4;
            for (int i = 0; i < 4; i++) exp_out[i] = word[8*i + b];
            if (k >= 64) exp_out = 4'b0000;
            checks++;
            if ({io_oe, io_sclk, io_out, done} !== {(k < 64) ? 4'hF : 4'h0, (k < 64) ? ((k / 2) % 2 == 1) : 1'b0,
                                                    exp_out, (k == 32 || k == 64)}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: oe/sclk/out/done=%b required %b", k, {io_oe, io_sclk, io_out, done},
                         {(k < 64) ? 4'hF : 4'h0, (k < 64) ? ((k / 2) % 2 == 1) : 1'b0, exp_out, (k == 32 || k == 64)});
            end
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = k;
                last_done = k;
            end
            if (k == 64) begin
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 32'h00FF_00FF) begin
                    errors++;
                    $display("FAIL b2b_rx: rx_valid=%b rx_data=%h required 1 00ff00ff", rx_valid, rx_data);
                end
            end
            tick();
        end
        checks++;
        if (ndone != 2 || (last_done - first_done) != 32) begin
            errors++;
            $display("FAIL b2b_done_pulses: count=%0d spacing=%0d required 2 and 32", ndone, last_done - first_done);
        end
    endtask

    task automatic test_overrun();
        int cyc;
        clkdiv = 8'd0; rx_ready = 1'b0; io_in_force = 4'b0001;
        send_word(32'hAAAA_0001, "ovr_w1");
        send_word(32'h5555_0002, "ovr_w2");
        wait_done(100, cyc);
        checks++;
        if (cyc < 0 || rx_valid !== 1'b1 || overrun !== 1'b0 || rx_data !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL ovr_first: cyc=%0d rx_valid=%b overrun=%b rx_data=%h required done 1 0 000000ff",
                     cyc, rx_valid, overrun, rx_data);
        end
        io_in_force = 4'b1000;
        send_word(32'h3333_0003, "ovr_w3");
        wait_done(100, cyc);
        checks++;
        if (cyc < 0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second: cyc=%0d overrun=%b required done and 1", cyc, overrun);
        end
        wait_done(100, cyc);
        checks++;
        if (cyc < 0 || overrun !== 1'b1 || rx_valid !== 1'b1 || rx_data !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL ovr_third: cyc=%0d overrun=%b rx_valid=%b rx_data=%h required done 1 1 000000ff",
                     cyc, overrun, rx_valid, rx_data);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0 || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear: overrun=%b rx_valid=%b required 0 1", overrun, rx_valid);
        end
    endtask

    task automatic test_abort();
        int ndone;
        clkdiv = 8'd0; rx_ready = 1'b0; ndone = 0;
        send_word(32'h5A5A_5A5A, "abort_w1");
        tick();                     // load, k = 0
        send_word(32'h1234_5678, "abort_w2");   // accepted into hold, k = 1
        for (int k = 1; k < 8; k++) tick();    // k = 8: LOW of bit 4
        checks++;
        if ({io_oe, io_sclk, io_out, in_ready} !== {4'hF, 1'b0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL abort_bit4: oe/sclk/out/in_ready=%b required %b", {io_oe, io_sclk, io_out, in_ready},
                     {4'hF, 1'b0, 4'hF, 1'b0});
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({io_oe, io_sclk, busy, done, io_out, in_ready} !== {4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL abort_idle: oe/sclk/busy/done/out/in_ready=%b required %b",
                     {io_oe, io_sclk, busy, done, io_out, in_ready}, {4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1});
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL abort_rx_kept: rx_valid=%b rx_data=%h required 1 000000ff", rx_valid, rx_data);
        end
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        enable = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (ndone != 0 || io_oe !== 4'h0) begin
            errors++;
            $display("FAIL abort_quiet: done_count=%0d io_oe=%b required 0 0000", ndone, io_oe);
        end
        rx_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_midword();
        int n, bad;
        clkdiv = 8'd2; n = 0; bad = 0;
        send_word(32'hCAFE_F00D, "rst_word");
        while (io_sclk !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (io_sclk !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_high: io_sclk=%b required 1", io_sclk);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, rx_valid, io_oe, io_sclk, busy, done, overrun, io_out} !== 14'b1_0_0000_0_0_0_0_0000) begin
            errors++;
            $display("FAIL rst_async_outputs: got %b required %b",
                     {in_ready, rx_valid, io_oe, io_sclk, busy, done, overrun, io_out}, 14'b1_0_0000_0_0_0_0_0000);
        end
        checks++;
        if (rx_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_async_rx_data: got %h required 00000000", rx_data);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (io_oe !== 4'h0 || done !== 1'b0 || rx_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_after_release: %0d active cycles required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_loopback();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
